systolic_skew_feeder: RTL and testbench
=======================================

SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 Parameter NUM_BITS, default 8: width of one matrix element.
REQ-002 Parameter N, default 4: array dimension; A and B are N x N.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  write one row vector into the operand buffer selected by wr_sel.
REQ-006 wr_sel  input  1  0 = A buffer, 1 = B buffer.
REQ-007 wr_row  input  $clog2(N)  row index written.
REQ-008 wr_data  input  NUM_BITS x [N]  row elements, index 0 = column 0.
REQ-009 start  input  1  request to stream the buffered A/B into the array.
REQ-010 busy_o  output  1  high while the feeder is streaming or finishing.
REQ-011 done_o  output  1  one-cycle pulse when the array has received all data.
REQ-012 valid_o  output  1  high on every cycle west_o/north_o carry feed or drain data.
REQ-013 west_o  output  NUM_BITS x [N]  skewed A data to the array's west_i; index i = array row i.
REQ-014 north_o  output  NUM_BITS x [N]  skewed B data to the array's north_i; index j = array column j.
REQ-015 clr_o  output  1  accumulator-clear pulse to the array (see Configuration).

Function
REQ-016 The FSM SHALL have states IDLE, FEED, DRAIN, DONE.
REQ-017 In IDLE, wr_en=1 SHALL write wr_data into row wr_row of the selected buffer; wr_en in any other state SHALL be ignored.
REQ-018 In IDLE, start=1 SHALL be accepted; call that edge cycle S. Simultaneous wr_en is dropped; start wins.
REQ-019 start outside IDLE SHALL be ignored; no queuing.
REQ-020 FEED: on cycle S+1+t, t = 0..2N-2: west_o[i] = A[i][t-i] if 0 <= t-i < N, else 0.
REQ-021 FEED: on the same cycles, north_o[j] = B[t-j][j] if 0 <= t-j < N, else 0.
REQ-022 DRAIN: on cycles S+2N .. S+3N-2 (N-1 cycles), west_o and north_o SHALL be all zeros with valid_o=1.
REQ-023 DONE: on cycle S+3N-1, done_o=1, valid_o=0, data outputs zero; on S+3N, return to IDLE.
REQ-024 busy_o SHALL be 1 from S+1 through S+3N-1 inclusive, 0 otherwise.
REQ-025 west_o, north_o, valid_o, done_o, busy_o SHALL be registered outputs; no combinational path from any input.
REQ-026 Buffers SHALL remain unchanged by streaming; a new start reuses the same contents.
REQ-027 The cycle counter SHALL be $clog2(3N) bits wide and SHALL never wrap during one operation.
REQ-028 Outputs SHALL be zero in IDLE.

Reset
REQ-029 rst=1 at any edge, including mid-FEED/DRAIN, SHALL force IDLE and clear both buffers to zero.
REQ-030 rst=1 SHALL force all outputs to 0 on the following cycle.
REQ-031 start or wr_en coincident with rst SHALL be ignored.

Configuration
REQ-032 Macro SKEW_CLEAR_EN: when defined, clr_o SHALL pulse high for exactly cycle S+1 (first FEED cycle) so the array zeroes its accumulators.
REQ-033 Without SKEW_CLEAR_EN, clr_o SHALL be constant 0 and no related logic is generated.

Verification
REQ-034 Identity, N=4: A=B=I, start at S -> west_o[i]=1 only at S+1+2i; north_o[j]=1 only at S+1+2j; all other feed cycles 0; done_o at S+11.
REQ-035 A[i][k]=10i+k, B = all 1s -> west_o[2] at S+3..S+6 = 20,21,22,23; zeros at S+1, S+2, S+7.
REQ-036 start repeated at S+4 and S+9 -> ignored; busy_o 1 for S+1..S+11; single done_o pulse at S+11.
REQ-037 rst at S+5 -> outputs 0 at S+6, busy_o 0; second start with no reload streams all zeros.
REQ-038 wr_en and start same cycle in IDLE -> write dropped; stream shows old contents.
REQ-039 With SKEW_CLEAR_EN: clr_o=1 only at S+1. Without it: clr_o=0 throughout all of the above.

Source files
------------

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: buffers N x N operands A/B and streams them skewed into a systolic array.
// Optional macro SKEW_CLEAR_EN drives clr_o high on the first feed cycle.
module systolic_skew_feeder #(
  parameter int NUM_BITS = 8,
  parameter int N = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic                           wr_sel,
  input  logic [$clog2(N)-1:0]           wr_row,
  input  logic [N-1:0][NUM_BITS-1:0]     wr_data,
  input  logic                           start,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           valid_o,
  output logic [N-1:0][NUM_BITS-1:0]     west_o,
  output logic [N-1:0][NUM_BITS-1:0]     north_o,
  output logic                           clr_o
);
  localparam int CW = $clog2(3 * N);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [N-1:0][N-1:0][NUM_BITS-1:0] r_a, r_b;
  logic [N-1:0][NUM_BITS-1:0] w_west, w_north;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = r_cnt + CW'(1);
    unique case (r_state)
      IDLE: begin
        w_state_nxt = start ? FEED : IDLE;
        w_cnt_nxt = '0;
      end
      FEED: w_state_nxt = (r_cnt == CW'(2 * N - 2)) ? DRAIN : FEED;
      DRAIN: w_state_nxt = (r_cnt == CW'(3 * N - 3)) ? DONE : DRAIN;
      DONE: begin
        w_state_nxt = IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end
  // Element k of lane i is due when the next count equals i + k.
  always_comb begin
    w_west = '0;
    w_north = '0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++)
        if (w_state_nxt == FEED && w_cnt_nxt == CW'(i + k)) begin
          w_west[i] = r_a[i][k];
          w_north[i] = r_b[k][i];
        end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_a <= '0;
      r_b <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      valid_o <= 1'b0;
      west_o <= '0;
      north_o <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
      busy_o <= w_state_nxt != IDLE;
      done_o <= w_state_nxt == DONE;
      valid_o <= w_state_nxt == FEED || w_state_nxt == DRAIN;
      west_o <= w_west;
      north_o <= w_north;
      if (r_state == IDLE && wr_en && !start) begin
        if (wr_sel) r_b[wr_row] <= wr_data;
        else r_a[wr_row] <= wr_data;
      end
    end
  end
`ifdef SKEW_CLEAR_EN
  logic r_clr;
  always_ff @(posedge clk) r_clr <= !rst && r_state == IDLE && start;
  assign clr_o = r_clr;
`else
  assign clr_o = 1'b0;
`endif
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: scoreboard plus table-driven spot checks for the skew feeder.
module tb_systolic_skew_feeder;
  localparam int W = 8;
  localparam int N = 4;
`ifdef SKEW_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
  logic [1:0] wr_row = '0;
  logic [N-1:0][W-1:0] wr_data = '0;
  logic busy_o, done_o, valid_o, clr_o;
  logic [N-1:0][W-1:0] west_o, north_o;
  systolic_skew_feeder #(.NUM_BITS(W), .N(N)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
    .wr_data(wr_data), .start(start), .busy_o(busy_o), .done_o(done_o),
    .valid_o(valid_o), .west_o(west_o), .north_o(north_o), .clr_o(clr_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [N*W-1:0] w;
    logic [N*W-1:0] n;
    logic v, b, d, c;
  } exp_t;
  typedef struct {
    int sc;
    int off;
    int idx;
    logic [W-1:0] w;
    logic [W-1:0] n;
    logic b;
    logic d;
  } vec_t;
  exp_t q[$];
  exp_t e;
  logic [W-1:0] ma[N][N];
  logic [W-1:0] mb[N][N];
  vec_t tbl[18];
  int n_chk = 0, n_fail = 0, n_done = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic push_stream();
    exp_t r;
    for (int t = 0; t < 3 * N; t++) begin
      r = '{default: '0};
      if (t <= 2 * N - 2) begin
        for (int i = 0; i < N; i++) begin
          if (t - i >= 0 && t - i < N) begin
            r.w[i*W+:W] = ma[i][t-i];
            r.n[i*W+:W] = mb[t-i][i];
          end
        end
      end
      r.v = t <= 3 * N - 3;
      r.b = t <= 3 * N - 2;
      r.d = t == 3 * N - 2;
      r.c = CLR_EN && t == 0;
      q.push_back(r);
    end
  endtask
  task automatic model_step();
    if (rst) begin
      q.delete();
      for (int i = 0; i < N; i++)
        for (int k = 0; k < N; k++) begin
          ma[i][k] = '0;
          mb[i][k] = '0;
        end
    end else if (q.size() == 0 && start) push_stream();
    else if (q.size() == 0 && wr_en)
      for (int k = 0; k < N; k++)
        if (wr_sel) mb[wr_row][k] = wr_data[k];
        else ma[wr_row][k] = wr_data[k];
    e = '{default: '0};
    if (q.size() != 0) e = q.pop_front();
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("west", 64'(west_o), 64'(e.w));
    chk("north", 64'(north_o), 64'(e.n));
    chk("valid", 64'(valid_o), 64'(e.v));
    chk("busy", 64'(busy_o), 64'(e.b));
    chk("done", 64'(done_o), 64'(e.d));
    chk("clr", 64'(clr_o), 64'(e.c));
    if (done_o) n_done++;
  endtask
  task automatic wr(input logic sel, input int row, input logic [N*W-1:0] d);
    wr_en = 1'b1;
    wr_sel = sel;
    wr_row = 2'(row);
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask
  task automatic load(input int sc);
    logic [N*W-1:0] ra, rb;
    for (int r = 0; r < N; r++) begin
      for (int k = 0; k < N; k++) begin
        ra[k*W+:W] = sc == 0 ? W'(r == k) : W'(10 * r + k);
        rb[k*W+:W] = sc == 0 ? W'(r == k) : W'(1);
      end
      wr(1'b0, r, ra);
      wr(1'b1, r, rb);
    end
  endtask
  task automatic run_table(input int sc);
    start = 1'b1;
    for (int off = 1; off <= 3 * N; off++) begin
      tick();
      start = 1'b0;
      foreach (tbl[j])
        if (tbl[j].sc == sc && tbl[j].off == off) begin
          chk($sformatf("tbl%0d_west%0d", sc, off), 64'(west_o[tbl[j].idx]), 64'(tbl[j].w));
          chk($sformatf("tbl%0d_north%0d", sc, off), 64'(north_o[tbl[j].idx]), 64'(tbl[j].n));
          chk($sformatf("tbl%0d_busy%0d", sc, off), 64'(busy_o), 64'(tbl[j].b));
          chk($sformatf("tbl%0d_done%0d", sc, off), 64'(done_o), 64'(tbl[j].d));
        end
    end
  endtask
  initial begin
    tbl = '{
      '{0, 1, 0, 1, 1, 1, 0}, '{0, 2, 0, 0, 0, 1, 0}, '{0, 3, 1, 1, 1, 1, 0},
      '{0, 3, 0, 0, 0, 1, 0}, '{0, 5, 2, 1, 1, 1, 0}, '{0, 7, 3, 1, 1, 1, 0},
      '{0, 6, 3, 0, 0, 1, 0}, '{0, 8, 3, 0, 0, 1, 0}, '{0, 11, 0, 0, 0, 1, 1},
      '{0, 12, 0, 0, 0, 0, 0},
      '{1, 1, 2, 0, 0, 1, 0}, '{1, 2, 2, 0, 0, 1, 0}, '{1, 3, 2, 20, 1, 1, 0},
      '{1, 4, 2, 21, 1, 1, 0}, '{1, 5, 2, 22, 1, 1, 0}, '{1, 6, 2, 23, 1, 1, 0},
      '{1, 7, 2, 0, 0, 1, 0}, '{1, 11, 0, 0, 0, 1, 1}
    };
    tick();
    tick();
    rst = 1'b0;
    tick();
    load(0);
    run_table(0);
    load(1);
    run_table(1);
    n_done = 0;
    for (int k = 0; k <= 3 * N; k++) begin
      start = k == 0 || k == 4 || k == 9;
      tick();
    end
    start = 1'b0;
    chk("single_done", 64'(n_done), 64'd1);
    for (int k = 0; k <= 5; k++) begin
      start = k == 0;
      rst = k == 5;
      tick();
    end
    rst = 1'b0;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_west", 64'(west_o), 64'd0);
    tick();
    start = 1'b1;
    for (int k = 0; k < 3 * N; k++) begin
      tick();
      start = 1'b0;
    end
    load(0);
    wr_en = 1'b1;
    wr_sel = 1'b0;
    wr_row = 2'd0;
    wr_data = '1;
    start = 1'b1;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    chk("drop_wr_west0", 64'(west_o[0]), 64'd1);
    for (int k = 1; k < 3 * N; k++) tick();
    rst = 1'b1;
    start = 1'b1;
    wr_en = 1'b1;
    wr_data = '1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    wr_en = 1'b0;
    tick();
    chk("rst_start_busy", 64'(busy_o), 64'd0);
    start = 1'b1;
    for (int k = 0; k < 3 * N + 1; k++) begin
      tick();
      start = 1'b0;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
